// File: rtl/exu_muldiv_pkg.sv
// Shared encodings and request descriptor for the iterative RV64M multiply/divide unit.
package exu_muldiv_pkg;

  localparam logic [4:0] OPCODE_ADD    = 5'b01100;
  localparam logic [4:0] OPCODE_ADDW   = 5'b01110;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Captured at accept; steers the final sign fix-up and result select.
  typedef struct packed {
    logic       legal;
    logic       special;
    logic       is_mul;
    logic       is_w;
    logic [2:0] funct3;
    logic       neg_q;
    logic       neg_r;
  } md_req_t;

  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/exu_div_iter.sv
// One restoring-division step on magnitudes: shift in next dividend bit, trial-subtract divisor.
module exu_div_iter #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so diff[XLEN] is a clean borrow flag.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/exu_muldiv.sv
// Iterative M-extension unit: shift-add multiply, restoring divide, valid/ready result.
// MULDIV_WORD_OPS_EN enables the W forms (N=32); leave undefined when XLEN=32.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            rd_wen,
  output logic [XLEN-1:0] rd_data
);

`ifdef MULDIV_WORD_OPS_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMIN = XLEN'($signed(32'h8000_0000));

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  md_state_e       state_q, state_d;
  md_req_t         req_q;
  logic [XLEN-1:0] a_q, hi_q, lo_q, res_q;
  logic [CW-1:0]   cnt_q;

  // ---- request decode ----
  logic            mul_in, w_in, legal_in, special_in, accept;
  logic            neg1, neg2, div_zero, ovf;
  logic [XLEN-1:0] x1, x2, m1, m2, spec_res;

  assign mul_in   = ~funct3_i[2];
  assign w_in     = WORD_EN && (opcode_i == OPCODE_ADDW);
  assign legal_in = (funct7_i == FUNCT7_MULDIV) &&
                    ((opcode_i == OPCODE_ADD) ||
                     (w_in && (funct3_i == FUNCT3_MUL || funct3_i[2])));

  assign x1 = !w_in ? op1_i :
              op1_signed(funct3_i) ? XLEN'($signed(op1_i[31:0])) : XLEN'(op1_i[31:0]);
  assign x2 = !w_in ? op2_i :
              op2_signed(funct3_i) ? XLEN'($signed(op2_i[31:0])) : XLEN'(op2_i[31:0]);

  assign neg1 = op1_signed(funct3_i) & x1[XLEN-1];
  assign neg2 = op2_signed(funct3_i) & x2[XLEN-1];
  assign m1   = neg1 ? -x1 : x1;
  assign m2   = neg2 ? -x2 : x2;

  assign div_zero   = !mul_in && (x2 == '0);
  assign ovf        = !mul_in && op2_signed(funct3_i) && (x2 == '1) &&
                      (x1 == (w_in ? WMIN : XMIN));
  assign special_in = !legal_in || div_zero || ovf;
  assign accept     = (state_q == MD_IDLE) && valid_i && !kill_i;

  always_comb begin
    spec_res = '0;
    if (legal_in) begin
      if (div_zero)  spec_res = funct3_i[1] ? wfix(w_in, x1) : '1;
      else if (ovf)  spec_res = funct3_i[1] ? '0 : wfix(w_in, x1);
    end
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = special_in ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (kill_i)              state_d = MD_IDLE;
        else if (cnt_q == CW'(1)) state_d = MD_DONE;
      end
      MD_DONE: if (kill_i || ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // ---- iteration datapath ----
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem, div_quo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);

  exu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem     (hi_q),
    .quo     (lo_q),
    .divisor (a_q),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      req_q <= '{legal: legal_in, special: special_in, is_mul: mul_in, is_w: w_in,
                 funct3: funct3_i, neg_q: neg1 ^ neg2, neg_r: neg1};
      // mul: a=multiplicand, lo=multiplier; div: a=divisor, lo=dividend aligned to MSB
      a_q   <= mul_in ? m1 : m2;
      hi_q  <= '0;
      lo_q  <= mul_in ? m2 : (w_in ? (m1 << (XLEN - 32)) : m1);
      res_q <= spec_res;
      cnt_q <= w_in ? CW'(32) : CW'(XLEN);
    end else if (state_q == MD_CALC) begin
      if (req_q.is_mul) {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
      else              {hi_q, lo_q} <= {div_rem, div_quo};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // ---- sign fix-up and result select, held stable by the frozen registers in DONE ----
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_res;

  assign prod   = {hi_q, lo_q};
  assign prod_s = req_q.neg_q ? -prod : prod;
  assign quo_s  = req_q.neg_q ? -lo_q : lo_q;
  assign rem_s  = req_q.neg_r ? -hi_q : hi_q;

  always_comb begin
    calc_res = '0;
    if (req_q.is_mul) begin
      // W multiply: 32 shifts leave the low product word at lo[XLEN-1 -: 32]
      if (req_q.is_w)                      calc_res = XLEN'($signed(lo_q[XLEN-1 -: 32]));
      else if (req_q.funct3 == FUNCT3_MUL) calc_res = prod_s[XLEN-1:0];
      else                                 calc_res = prod_s[2*XLEN-1:XLEN];
    end else begin
      calc_res = wfix(req_q.is_w, req_q.funct3[1] ? rem_s : quo_s);
    end
  end

  assign ready_o = (state_q == MD_IDLE);
  assign valid_o = (state_q == MD_DONE);
  assign rd_wen  = valid_o && req_q.legal;
  assign rd_data = !valid_o ? '0 : (req_q.special ? res_q : calc_res);

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: results, latency, special cases, kill, stall, reset.
module tb_exu_muldiv;
  import exu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, kill_i, valid_o, ready_i, rd_wen;
  logic [4:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [63:0] op1_i, op2_i, rd_data;

  int errs   = 0;
  int checks = 0;
  int lat;
  logic seen;

  exu_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .op1_i(op1_i), .op2_i(op2_i), .kill_i(kill_i), .valid_o(valid_o),
    .ready_i(ready_i), .rd_wen(rd_wen), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request; return at the first negedge where valid_o is seen.
  // lat counts negedges after the accept edge (1 = cycle right after accept).
  task automatic run_op(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, output int l);
    @(negedge clk);
    valid_i = 1'b1; opcode_i = opc; funct3_i = f3; funct7_i = f7; op1_i = a; op2_i = b;
    @(posedge clk);
    l = 0;
    do begin
      @(negedge clk);
      valid_i = 1'b0;
      l++;
    end while (!valid_o && l < 200);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    opcode_i = '0; funct3_i = '0; funct7_i = '0; op1_i = '0; op2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_wen",   rd_wen,  1'b0);
    chk("rst_data",  rd_data, 64'h0);
    rst = 1'b0;

    run_op(OPCODE_ADD, FUNCT3_MUL, 7'h01, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat);
    chk("mul_data", rd_data, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_wen",  rd_wen,  1'b1);
    chk("mul_lat",  64'(lat), 64'd65);

    run_op(OPCODE_ADD, FUNCT3_MULHU, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("mulhu_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op(OPCODE_ADD, FUNCT3_MULHSU, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat);
    chk("mulhsu_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(OPCODE_ADD, FUNCT3_MULH, 7'h01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000, lat);
    chk("mulh_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(OPCODE_ADD, FUNCT3_DIV, 7'h01, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, lat);
    chk("div_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_lat",  64'(lat), 64'd65);

    run_op(OPCODE_ADD, FUNCT3_REM, 7'h01, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, lat);
    chk("rem_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op(OPCODE_ADD, FUNCT3_REMU, 7'h01, 64'd100, 64'd7, lat);
    chk("remu_data", rd_data, 64'd2);

    run_op(OPCODE_ADD, FUNCT3_DIVU, 7'h01, 64'd5, 64'd0, lat);
    chk("divu0_data", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu0_lat",  64'(lat), 64'd1);

    run_op(OPCODE_ADD, FUNCT3_REMU, 7'h01, 64'd5, 64'd0, lat);
    chk("remu0_data", rd_data, 64'd5);

    run_op(OPCODE_ADD, FUNCT3_DIV, 7'h01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("ovf_div_data", rd_data, 64'h8000_0000_0000_0000);
    chk("ovf_div_lat",  64'(lat), 64'd1);

    run_op(OPCODE_ADD, FUNCT3_REM, 7'h01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    chk("ovf_rem_data", rd_data, 64'h0);
    chk("ovf_rem_lat",  64'(lat), 64'd1);

    run_op(OPCODE_ADDW, FUNCT3_DIV, 7'h01, 64'h1_8000_0000, 64'd2, lat);
`ifdef MULDIV_WORD_OPS_EN
    chk("divw_data", rd_data, 64'hFFFF_FFFF_C000_0000);
    chk("divw_wen",  rd_wen,  1'b1);
    chk("divw_lat",  64'(lat), 64'd33);
`else
    chk("divw_data", rd_data, 64'h0);
    chk("divw_wen",  rd_wen,  1'b0);
    chk("divw_lat",  64'(lat), 64'd1);
`endif

    run_op(OPCODE_ADD, FUNCT3_MUL, 7'h00, 64'd3, 64'd4, lat);
    chk("illegal_wen",  rd_wen,  1'b0);
    chk("illegal_data", rd_data, 64'h0);
    chk("illegal_lat",  64'(lat), 64'd1);

    // Kill during CALC: no result, unit idle next cycle.
    @(negedge clk);
    valid_i = 1'b1; opcode_i = OPCODE_ADD; funct3_i = FUNCT3_MUL; funct7_i = 7'h01;
    op1_i = 64'd9; op2_i = 64'd9;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_ready", ready_o, 1'b1);
    chk("kill_valid", valid_o, 1'b0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    chk("kill_no_valid", seen, 1'b0);

    // Kill in IDLE blocks acceptance.
    @(negedge clk);
    valid_i = 1'b1; kill_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle_ready", ready_o, 1'b1);

    // Writeback stall: result held stable while ready_i low.
    ready_i = 1'b0;
    run_op(OPCODE_ADD, FUNCT3_DIVU, 7'h01, 64'd100, 64'd7, lat);
    chk("stall_data0", rd_data, 64'd14);
    chk("stall_lat",   64'(lat), 64'd65);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", valid_o, 1'b1);
      chk("stall_data",  rd_data, 64'd14);
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("post_hs_ready", ready_o, 1'b1);
    chk("post_hs_valid", valid_o, 1'b0);

    // Reset in the middle of CALC.
    @(negedge clk);
    valid_i = 1'b1; opcode_i = OPCODE_ADD; funct3_i = FUNCT3_DIV; funct7_i = 7'h01;
    op1_i = 64'd50; op2_i = 64'd3;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ready_o, 1'b1);
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_wen",   rd_wen,  1'b0);
    chk("midrst_data",  rd_data, 64'h0);
    rst = 1'b0;

    run_op(OPCODE_ADD, FUNCT3_DIV, 7'h01, 64'd50, 64'hFFFF_FFFF_FFFF_FFFD, lat);
    chk("div_neg_data", rd_data, 64'hFFFF_FFFF_FFFF_FFF0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
# exu_muldiv

Iterative RV64M multiply/divide execution unit, parametrised in datapath width, sitting beside the single-cycle ALU in the execute stage. It takes decoded operands for `OPCODE_ADD`/`OPCODE_ADDW` instructions with funct7 = 7'b0000001 and computes results over multiple cycles. Results return to writeback through a valid/ready handshake. A kill input aborts the operation in flight, so a redirect from a taken branch or jump squashes it.

## Interface
- `XLEN`, 64: datapath width; 32 or 64.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request.
- `opcode_i`  in  5  `OPCODE_ADD` or `OPCODE_ADDW`.
- `funct3_i`  in  3  M-extension operation select.
- `funct7_i`  in  7  must be 7'b0000001 for a legal request.
- `op1_i`  in  XLEN  rs1 value.
- `op2_i`  in  XLEN  rs2 value.
- `kill_i`  in  1  abort the in-flight or presented request.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  writeback accepts the result.
- `rd_wen`  out  1  write enable qualifying `rd_data`.
- `rd_data`  out  XLEN  result.

## Operation
- **States and transitions**
  - IDLE: `ready_o`=1. Moves to CALC when `valid_i` && !`kill_i`, capturing opcode, funct3, operands and iteration count.
  - CALC: one iteration per cycle, down-counter from N.
  - DONE: holds `valid_o`=1 until `ready_i`, then returns to IDLE.
- **Iteration count N**: XLEN for full-width ops; 32 for W ops.
- **Multiply** (MUL, MULH, MULHSU, MULHU, MULW)
  - Radix-2 shift-add on operand magnitudes into a 2N-bit product.
  - Product negated at completion if operand signs differ.
  - MULH: signed×signed. MULHSU: op1 signed, op2 unsigned. MULHU: unsigned×unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- **Divide** (DIV, DIVU, REM, REMU and W forms)
  - Restoring division on magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder takes the sign of op1.
- **Special cases** skip CALC and go straight from IDLE to DONE:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0.
  - Illegal funct7: `rd_wen`=0, `rd_data`=0.
- **W ops**
  - Operands taken from bits [31:0]; sign- or zero-extended to 32-bit magnitude as the op requires.
  - Result sign-extended from bit 31 to XLEN.
- `rd_wen` = `valid_o` && legal request.
- **kill_i**
  - In CALC or DONE: forces IDLE next cycle; no `valid_o` is produced.
  - In IDLE: blocks acceptance of the presented request.
- **Reset values**: state IDLE, `ready_o`=1, `valid_o`=0, `rd_wen`=0, `rd_data`=0, internal registers 0.

## Timing
- Accept on the edge where `valid_i`&&`ready_o`; `ready_o` falls in the next cycle.
- **Normal latency**: `valid_o` rises N+1 cycles after accept (N CALC cycles, then DONE). N=64: 65 cycles. W ops: 33 cycles.
- **Special-case latency**: `valid_o` rises 1 cycle after accept.
- `rd_data`/`rd_wen` are stable while `valid_o` && !`ready_i`.
- **Back-to-back**: `ready_o` returns the cycle after the DONE handshake. No acceptance is possible in the same cycle as a handshake (bubble of 1).
- **Priority**: `rst` > `kill_i` > handshake.
- **Simultaneous `kill_i` and `ready_i` in DONE**: kill wins; writeback must ignore that `valid_o`.
- Reset asserted mid-CALC returns to IDLE next edge with all outputs at reset values.

## Configuration
- `MULDIV_WORD_OPS_EN`
  - Defined: W forms (MULW, DIVW, DIVUW, REMW, REMUW) are supported, with N=32.
  - Undefined: `OPCODE_ADDW` requests are treated as illegal (1-cycle DONE, `rd_wen`=0).
  - Must be left undefined when XLEN=32.

## Structure
- **Shared `defines.v`** gains:
  - `FUNCT7_MULDIV`.
  - `FUNCT3_MUL`, `FUNCT3_MULH`, `FUNCT3_MULHSU`, `FUNCT3_MULHU`, `FUNCT3_DIV`, `FUNCT3_DIVU`, `FUNCT3_REM`, `FUNCT3_REMU`.
  - State encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- **Sub-module `exu_div_iter`**: restoring-divider datapath; per-step remainder/quotient update, XLEN-parametrised. The FSM and multiplier stay in `exu_muldiv`.

## Test plan
- MUL op1=7, op2=−3 → `valid_o` at accept+65, `rd_data`=0xFFFF_FFFF_FFFF_FFEB, `rd_wen`=1.
- MULHU op1=op2=0xFFFF_FFFF_FFFF_FFFF → `rd_data`=0xFFFF_FFFF_FFFF_FFFE. MULHSU op1=−1, op2=2 → `rd_data`=0xFFFF_FFFF_FFFF_FFFF.
- DIV op1=−20, op2=6 → quotient −3. REM same operands → −2. DIVU op1=5, op2=0 → `rd_data`=all ones, `valid_o` at accept+1.
- DIV op1=0x8000_0000_0000_0000, op2=−1 → quotient 0x8000_0000_0000_0000, REM → 0, both at accept+1.
- DIVW op1=0x1_8000_0000, op2=2 (macro on) → `rd_data`=0xFFFF_FFFF_C000_0000 at accept+33. Same request with macro off → `rd_wen`=0 at accept+1.
- `kill_i` pulsed at CALC cycle 10 → no `valid_o`, `ready_o`=1 next cycle. `ready_i` held low 5 cycles in DONE → `rd_data` stable throughout.
